// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display write path.
// Segment codes are packed {g,f,e,d,c,b,a}, with 1 meaning the segment is lit.
package seven_seg_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int SEG_W  = 7;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] COUNT_MAX = 5'd16;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to seven-segment encoder.
// Shared by any display path that needs the standard hex glyphs.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  // Standard hex glyph lookup.
  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_reg_writer.sv
// Write side of the 16-entry seven-segment register file: blanking sweep, digit append.
// Define SEG_BACKSPACE_EN to add the BKSP port and the erase-last-digit path.
module seven_seg_reg_writer
  import seven_seg_pkg::*;
#(
  parameter int unsigned WRAP = 0
)
(
  input  logic              CLK,
  input  logic              CLRN,
  input  logic [3:0]        DIG_IN,
  input  logic              DIG_VALID,
  output logic              DIG_READY,
  input  logic              CLR_REQ,
`ifdef SEG_BACKSPACE_EN
  input  logic              BKSP,
`endif
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [SEG_W-1:0]  WDATA,
  output logic [CNT_W-1:0]  COUNT,
  output logic              FULL,
  output logic              BUSY
);

  localparam bit WRAP_EN = (WRAP != 0);

  state_e              state_r, state_s;
  logic [CNT_W-1:0]    sweep_r, sweep_s;
  logic [ADDR_W-1:0]   ptr_r, ptr_s;
  logic [CNT_W-1:0]    count_r, count_s;
  logic                we_r, we_s;
  logic [ADDR_W-1:0]   wa_r, wa_s;
  logic [SEG_W-1:0]    wdata_r, wdata_s;
  logic [SEG_W-1:0]    seg_s;
  logic                full_s;
  logic                ready_s;

  hex_to_seg7 u_enc (
    .hex (DIG_IN),
    .seg (seg_s)
  );

  assign full_s    = (count_r == COUNT_MAX);
  assign DIG_READY = ready_s;
  assign WE        = we_r;
  assign WA        = wa_r;
  assign WDATA     = wdata_r;
  assign COUNT     = count_r;
  assign FULL      = full_s;
  assign BUSY      = (state_r == CLEAR);

  // Ready only in IDLE, and never while a higher-priority request is present.
  always_comb begin
    ready_s = 1'b0;
    if (state_r == IDLE) begin
`ifdef SEG_BACKSPACE_EN
      ready_s = !CLR_REQ && !BKSP && (!full_s || WRAP_EN);
`else
      ready_s = !CLR_REQ && (!full_s || WRAP_EN);
`endif
    end else begin
      ready_s = 1'b0;
    end
  end

  // Next state and next write; CLR_REQ wins over backspace, which wins over a digit.
  always_comb begin
    state_s = state_r;
    sweep_s = sweep_r;
    ptr_s   = ptr_r;
    count_s = count_r;
    we_s    = 1'b0;
    wa_s    = wa_r;
    wdata_s = wdata_r;
    if (CLR_REQ) begin
      // Restarting issues the address-0 blank immediately, so the sweep resumes at 1.
      state_s = CLEAR;
      sweep_s = 5'd1;
      ptr_s   = 4'd0;
      count_s = 5'd0;
      we_s    = 1'b1;
      wa_s    = 4'd0;
      wdata_s = SEG_BLANK;
    end else if (state_r == CLEAR) begin
      if (sweep_r < COUNT_MAX) begin
        we_s    = 1'b1;
        wa_s    = sweep_r[ADDR_W-1:0];
        wdata_s = SEG_BLANK;
        sweep_s = sweep_r + 5'd1;
      end else begin
        // Extra cycle lets the address-15 blank land before digits are accepted.
        state_s = IDLE;
        sweep_s = 5'd0;
        ptr_s   = 4'd0;
        count_s = 5'd0;
      end
`ifdef SEG_BACKSPACE_EN
    end else if (BKSP) begin
      if (count_r != 5'd0) begin
        ptr_s   = ptr_r - 4'd1;
        count_s = count_r - 5'd1;
        we_s    = 1'b1;
        wa_s    = ptr_r - 4'd1;
        wdata_s = SEG_BLANK;
      end else begin
        we_s    = 1'b0;
      end
`endif
    end else if (DIG_VALID && ready_s) begin
      we_s    = 1'b1;
      wa_s    = ptr_r;
      wdata_s = seg_s;
      ptr_s   = ptr_r + 4'd1;
      if (!full_s) begin
        count_s = count_r + 5'd1;
      end else begin
        count_s = count_r;
      end
    end else begin
      we_s    = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_s;
    end
  end

  // Sweep, pointer, count and registered write port.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      sweep_r <= 5'd0;
      ptr_r   <= 4'd0;
      count_r <= 5'd0;
      we_r    <= 1'b0;
      wa_r    <= 4'd0;
      wdata_r <= SEG_BLANK;
    end else begin
      sweep_r <= sweep_s;
      ptr_r   <= ptr_s;
      count_r <= count_s;
      we_r    <= we_s;
      wa_r    <= wa_s;
      wdata_r <= wdata_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_reg_writer.sv
// Self-checking bench for seven_seg_reg_writer (WRAP=0 and WRAP=1 instances).
// Backspace scenario runs only when SEG_BACKSPACE_EN is defined.
module tb_seven_seg_reg_writer;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       CLRN = 1'b0;
  logic [3:0] DIG_IN = 4'd0;
  logic       DIG_VALID = 1'b0;
  logic       CLR_REQ = 1'b0;
  logic       DIG_READY, WE, FULL, BUSY;
  logic [3:0] WA;
  logic [6:0] WDATA;
  logic [4:0] COUNT;

  logic       w_clrn = 1'b0;
  logic [3:0] w_dig_in = 4'd0;
  logic       w_valid = 1'b0;
  logic       w_clr = 1'b0;
  logic       w_ready, w_we, w_full, w_busy;
  logic [3:0] w_wa;
  logic [6:0] w_wdata;
  logic [4:0] w_count;
`ifdef SEG_BACKSPACE_EN
  logic       BKSP = 1'b0;
  logic       w_bksp = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_reg_writer #(.WRAP(0)) dut (
    .CLK(CLK), .CLRN(CLRN), .DIG_IN(DIG_IN), .DIG_VALID(DIG_VALID), .DIG_READY(DIG_READY),
    .CLR_REQ(CLR_REQ),
`ifdef SEG_BACKSPACE_EN
    .BKSP(BKSP),
`endif
    .WE(WE), .WA(WA), .WDATA(WDATA), .COUNT(COUNT), .FULL(FULL), .BUSY(BUSY)
  );

  seven_seg_reg_writer #(.WRAP(1)) dut_w (
    .CLK(CLK), .CLRN(w_clrn), .DIG_IN(w_dig_in), .DIG_VALID(w_valid), .DIG_READY(w_ready),
    .CLR_REQ(w_clr),
`ifdef SEG_BACKSPACE_EN
    .BKSP(w_bksp),
`endif
    .WE(w_we), .WA(w_wa), .WDATA(w_wdata), .COUNT(w_count), .FULL(w_full), .BUSY(w_busy)
  );

  // Stimulus-only helper: pulse CLR_REQ and wait until the sweep has finished.
  task automatic clear_and_wait();
    @(negedge CLK);
    CLR_REQ = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CLR_REQ = 1'b0;
    repeat (16) @(negedge CLK);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({WE, WA, WDATA, DIG_READY, COUNT, FULL, BUSY} !== {1'b0, 4'd0, 7'd0, 1'b0, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: got WE=%b WA=%0d WDATA=%h RDY=%b COUNT=%0d FULL=%b BUSY=%b, want 0 0 00 0 0 0 1",
               WE, WA, WDATA, DIG_READY, COUNT, FULL, BUSY);
    end
  endtask

  // Releases CLRN and checks the full 16-address blanking sweep.
  task automatic test_sweep(input string name);
    @(negedge CLK);
    CLRN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({WE, WA, WDATA, BUSY, DIG_READY} !== {1'b1, 4'(i), 7'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s_write%0d: got WE=%b WA=%0d WDATA=%h BUSY=%b RDY=%b, want 1 %0d 00 1 0",
                 name, i, WE, WA, WDATA, BUSY, DIG_READY, i);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({WE, BUSY, DIG_READY, COUNT} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL %s_cycle17: got WE=%b BUSY=%b RDY=%b COUNT=%0d, want 0 0 1 0",
               name, WE, BUSY, DIG_READY, COUNT);
    end
  endtask

  task automatic test_digits();
    logic [3:0] digs [3];
    logic [6:0] codes [3];
    digs  = '{4'h1, 4'h2, 4'h3};
    codes = '{7'h06, 7'h5B, 7'h4F};
    for (int i = 0; i < 3; i++) begin
      DIG_IN = digs[i];
      DIG_VALID = 1'b1;
      #1;
      checks++;
      if (DIG_READY !== 1'b1) begin
        errors++;
        $display("FAIL digits_ready%0d: got %b want 1", i, DIG_READY);
      end
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({WE, WA, WDATA, COUNT} !== {1'b1, 4'(i), codes[i], 5'(i + 1)}) begin
        errors++;
        $display("FAIL digits_write%0d: got WE=%b WA=%0d WDATA=%h COUNT=%0d, want 1 %0d %h %0d",
                 i, WE, WA, WDATA, COUNT, i, codes[i], i + 1);
      end
    end
    DIG_VALID = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({WE, COUNT} !== {1'b0, 5'd3}) begin
      errors++;
      $display("FAIL digits_idle: got WE=%b COUNT=%0d, want 0 3", WE, COUNT);
    end
  endtask

  task automatic test_full();
    clear_and_wait();
    DIG_IN = 4'h8;
    DIG_VALID = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({WE, WA, WDATA, COUNT} !== {1'b1, 4'(i), 7'h7F, 5'(i + 1)}) begin
        errors++;
        $display("FAIL full_write%0d: got WE=%b WA=%0d WDATA=%h COUNT=%0d, want 1 %0d 7f %0d",
                 i, WE, WA, WDATA, COUNT, i, i + 1);
      end
    end
    #1;
    checks++;
    if ({FULL, DIG_READY} !== 2'b10) begin
      errors++;
      $display("FAIL full_flags: got FULL=%b RDY=%b, want 1 0", FULL, DIG_READY);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({WE, COUNT, FULL} !== {1'b0, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL full_held: got WE=%b COUNT=%0d FULL=%b, want 0 16 1", WE, COUNT, FULL);
    end
    DIG_VALID = 1'b0;
  endtask

  task automatic test_clr_mid();
    bit found;
    found = 1'b0;
    @(negedge CLK);
    CLR_REQ = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    CLR_REQ = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (WE === 1'b1 && WA === 4'd9) begin
        found = 1'b1;
      end else begin
        @(posedge CLK);
        @(negedge CLK);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL clr_mid_wait: sweep address 9 not seen within 40 cycles, want seen");
    end
    CLR_REQ = 1'b1;
    DIG_VALID = 1'b1;
    DIG_IN = 4'h5;
    #1;
    checks++;
    if (DIG_READY !== 1'b0) begin
      errors++;
      $display("FAIL clr_mid_ready: got %b want 0", DIG_READY);
    end
    @(posedge CLK);
    @(negedge CLK);
    CLR_REQ = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({WE, WA, WDATA, COUNT} !== {1'b1, 4'(i), 7'd0, 5'd0}) begin
        errors++;
        $display("FAIL clr_mid_write%0d: got WE=%b WA=%0d WDATA=%h COUNT=%0d, want 1 %0d 00 0",
                 i, WE, WA, WDATA, COUNT, i);
      end
      if (i == 15) begin
        DIG_VALID = 1'b0;
      end else begin
        @(posedge CLK);
        @(negedge CLK);
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({WE, COUNT, BUSY, DIG_READY} !== {1'b0, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clr_mid_end: got WE=%b COUNT=%0d BUSY=%b RDY=%b, want 0 0 0 1",
               WE, COUNT, BUSY, DIG_READY);
    end
  endtask

  task automatic test_random();
    int  m_count, m_ptr, m_next_blank;
    bit  m_busy, v, c, exp_rdy, exp_we;
    logic [3:0] d, exp_wa;
    logic [6:0] exp_wd;
    m_count = 0; m_ptr = 0; m_next_blank = 0; m_busy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      v = ($urandom_range(0, 9) < 7);
      d = 4'($urandom_range(0, 15));
      c = (i == 0) || ($urandom_range(0, 59) == 0);
      DIG_VALID = v; DIG_IN = d; CLR_REQ = c;
      exp_rdy = !m_busy && !c && (m_count < 16);
      #1;
      checks++;
      if (DIG_READY !== exp_rdy) begin
        errors++;
        $display("FAIL random_ready%0d: got %b want %b", i, DIG_READY, exp_rdy);
      end
      exp_we = 1'b0; exp_wa = 4'd0; exp_wd = 7'd0;
      if (c) begin
        exp_we = 1'b1; m_busy = 1'b1; m_next_blank = 1; m_count = 0; m_ptr = 0;
      end else if (m_busy) begin
        if (m_next_blank < 16) begin
          exp_we = 1'b1; exp_wa = 4'(m_next_blank); m_next_blank++;
        end else begin
          m_busy = 1'b0;
        end
      end else if (v && exp_rdy) begin
        exp_we = 1'b1; exp_wa = 4'(m_ptr); exp_wd = seg_ref[d];
        m_ptr = (m_ptr + 1) % 16;
        if (m_count < 16) m_count++;
      end
      @(posedge CLK);
      #1;
      checks++;
      if (WE !== exp_we || (exp_we && (WA !== exp_wa || WDATA !== exp_wd)) ||
          COUNT !== 5'(m_count) || FULL !== (m_count == 16) || BUSY !== m_busy) begin
        errors++;
        $display("FAIL random_out%0d: got WE=%b WA=%0d WDATA=%h COUNT=%0d FULL=%b BUSY=%b, want %b %0d %h %0d %b %b",
                 i, WE, WA, WDATA, COUNT, FULL, BUSY, exp_we, exp_wa, exp_wd, m_count, m_count == 16, m_busy);
      end
    end
    @(negedge CLK);
    DIG_VALID = 1'b0;
    CLR_REQ = 1'b0;
  endtask

`ifdef SEG_BACKSPACE_EN
  task automatic test_backspace();
    clear_and_wait();
    DIG_VALID = 1'b1;
    DIG_IN = 4'h4;
    @(posedge CLK);
    @(negedge CLK);
    DIG_IN = 4'h5;
    @(posedge CLK);
    @(negedge CLK);
    DIG_VALID = 1'b0;
    BKSP = 1'b1;
    #1;
    checks++;
    if (DIG_READY !== 1'b0) begin
      errors++;
      $display("FAIL bksp_ready: got %b want 0", DIG_READY);
    end
    @(posedge CLK);
    @(negedge CLK);
    BKSP = 1'b0;
    checks++;
    if ({WE, WA, WDATA, COUNT} !== {1'b1, 4'd1, 7'd0, 5'd1}) begin
      errors++;
      $display("FAIL bksp_erase: got WE=%b WA=%0d WDATA=%h COUNT=%0d, want 1 1 00 1", WE, WA, WDATA, COUNT);
    end
    DIG_VALID = 1'b1;
    DIG_IN = 4'h7;
    @(posedge CLK);
    @(negedge CLK);
    DIG_VALID = 1'b0;
    checks++;
    if ({WE, WA, WDATA, COUNT} !== {1'b1, 4'd1, 7'h07, 5'd2}) begin
      errors++;
      $display("FAIL bksp_rewrite: got WE=%b WA=%0d WDATA=%h COUNT=%0d, want 1 1 07 2", WE, WA, WDATA, COUNT);
    end
    BKSP = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({WE, WA, COUNT} !== {1'b1, 4'd0, 5'd0}) begin
      errors++;
      $display("FAIL bksp_to_zero: got WE=%b WA=%0d COUNT=%0d, want 1 0 0", WE, WA, COUNT);
    end
    @(posedge CLK);
    @(negedge CLK);
    BKSP = 1'b0;
    checks++;
    if ({WE, COUNT} !== {1'b0, 5'd0}) begin
      errors++;
      $display("FAIL bksp_empty: got WE=%b COUNT=%0d, want 0 0", WE, COUNT);
    end
  endtask
`endif

  task automatic test_reset_mid();
    clear_and_wait();
    DIG_IN = 4'h3;
    DIG_VALID = 1'b1;
    @(posedge CLK);
    #2;
    CLRN = 1'b0;
    #1;
    checks++;
    if ({WE, WA, WDATA, DIG_READY, COUNT, FULL, BUSY} !== {1'b0, 4'd0, 7'd0, 1'b0, 5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid: got WE=%b WA=%0d WDATA=%h RDY=%b COUNT=%0d FULL=%b BUSY=%b, want 0 0 00 0 0 0 1",
               WE, WA, WDATA, DIG_READY, COUNT, FULL, BUSY);
    end
    DIG_VALID = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    w_clrn = 1'b1;
    repeat (17) @(negedge CLK);
    w_dig_in = 4'h8;
    w_valid = 1'b1;
    repeat (16) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({w_count, w_full, w_ready} !== {5'd16, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_full: got COUNT=%0d FULL=%b RDY=%b, want 16 1 1", w_count, w_full, w_ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({w_we, w_wa, w_wdata, w_count, w_full} !== {1'b1, 4'(i), 7'h7F, 5'd16, 1'b1}) begin
        errors++;
        $display("FAIL wrap_write%0d: got WE=%b WA=%0d WDATA=%h COUNT=%0d FULL=%b, want 1 %0d 7f 16 1",
                 i, w_we, w_wa, w_wdata, w_count, w_full, i);
      end
    end
    w_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep("sweep");
    test_digits();
    test_full();
    test_clr_mid();
    test_random();
`ifdef SEG_BACKSPACE_EN
    test_backspace();
`endif
    test_reset_mid();
    test_sweep("resweep");
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_reg_writer.md
# seven_seg_reg_writer

- Write-side companion to the 16-entry 7-bit seven-segment register file.
- Accepts a stream of 4-bit hex digits from the ATM keypad/control logic over a valid/ready handshake.
- Encodes each digit to a segment code and writes it to successive register-file addresses.
- Also performs a blanking sweep after reset or on request, and optional backspace, so the display path only ever reads settled codes.

## Interface
Parameters:
- WRAP, 0: 0 = refuse digits when all 16 entries are written; 1 = wrap pointer and overwrite from address 0.

Ports:
- CLK  in  1  single clock, rising edge.
- CLRN  in  1  asynchronous, active-low reset.
- DIG_IN  in  4  hex digit 0x0–0xF.
- DIG_VALID  in  1  DIG_IN is valid.
- DIG_READY  out  1  block accepts a digit this cycle.
- CLR_REQ  in  1  single-cycle pulse; restart blanking sweep.
- BKSP  in  1  single-cycle pulse; erase last digit. Only present with SEG_BACKSPACE_EN.
- WE  out  1  register-file write enable.
- WA  out  4  register-file write address.
- WDATA  out  7  segment code {g,f,e,d,c,b,a}; 1 = lit.
- COUNT  out  5  digits currently held, 0–16.
- FULL  out  1  COUNT == 16.
- BUSY  out  1  blanking sweep in progress.

## Operation
- States: CLEAR, IDLE.
- CLEAR:
  - Sweep counter runs 0→15, one write per cycle: WE=1, WA=sweep, WDATA=7'b0000000.
  - After address 15 is written, go to IDLE with write pointer=0, COUNT=0.
  - BUSY=1 throughout CLEAR; DIG_READY=0.
- IDLE:
  - DIG_READY = !CLR_REQ && !BKSP && (!FULL || WRAP).
  - DIG_READY is combinational on CLR_REQ/BKSP; no other input paths.
- Accept (DIG_VALID && DIG_READY at an edge):
  - Register WE=1, WA=ptr, WDATA=seg(DIG_IN).
  - ptr+1 mod 16.
  - COUNT+1, saturating at 16.
- Segment codes, standard hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- WRAP=0, full: DIG_READY=0; DIG_VALID is ignored and the producer holds the digit.
- WRAP=1, full: writes continue at ptr (wrapping 15→0); COUNT stays 16, FULL stays 1.
- Priority when events coincide: CLR_REQ > BKSP > digit.
  - CLR_REQ in any state, including mid-sweep: next cycle is sweep address 0, COUNT=0, ptr=0.
  - A coincident digit is not accepted.
- WE is 0 on every cycle without a sweep write, accept, or backspace.

## Timing
- Reset values while CLRN=0: WE=0, WA=0, WDATA=0, DIG_READY=0, COUNT=0, FULL=0, BUSY=1; state=CLEAR, sweep=0.
- Reset assertion is asynchronous, mid-sweep or mid-write; any pending write is dropped.
- Sweep writes occupy the first 16 cycles after CLRN deasserts. DIG_READY rises in cycle 17.
- Accept at edge k:
  - WE/WA/WDATA valid during cycle k→k+1; the register file captures at edge k+1.
  - COUNT/FULL update at edge k.
- Throughput: one digit per cycle, back-to-back.

## Configuration
- SEG_BACKSPACE_EN defined: BKSP port present.
  - BKSP in IDLE with COUNT>0: ptr−1 mod 16, write 7'b0000000 at the new ptr (same 1-cycle latency), COUNT−1, FULL clears.
  - BKSP with COUNT==0: no write, no change.
  - BKSP during CLEAR: ignored.
- SEG_BACKSPACE_EN undefined: no BKSP port and no decrement logic. DIG_READY = !CLR_REQ && (!FULL || WRAP).

## Structure
- Shared package seven_seg_pkg holds:
  - 16 segment-code constants and SEG_BLANK.
  - State enum {CLEAR, IDLE}.
  - DEPTH=16 and address width 4.
- Sub-module hex_to_seg7: combinational 4-bit→7-bit encoder, reusable by other display paths.

## Test plan
- Release CLRN: WE high for exactly 16 cycles, WA 0..15, WDATA=00 each; BUSY falls and DIG_READY rises on cycle 17.
- Send digits 1,2,3 back-to-back: writes (WA0,06), (WA1,5B), (WA2,4F) on consecutive cycles; COUNT=3.
- WRAP=0, send 17 digits of 0x8: 16 writes of 7F, FULL=1, DIG_READY=0, 17th digit held; WRAP=1: 17th writes WA0=7F, COUNT=16.
- CLR_REQ at sweep address 9 with DIG_VALID high: next WA=0, sweep restarts, 16 blank writes total after request, no digit accepted.
- SEG_BACKSPACE_EN, digits 4,5 then BKSP: write (WA1,00), COUNT=1; next digit 7 writes (WA1,07); BKSP with COUNT=0 yields no WE.
- CLRN asserted during digit writes: all outputs to reset values immediately; after release, full sweep repeats.
